xmit_link_arbiter: RTL and testbench

Block-granular arbiter that shares one GXB transmit lane between two event-block FIFOs, src0 and src1, each carrying 16-bit words with first/last flags. It sits between the transmit FIFOs and the lane's tx_datain/tx_ctrlenable pair, in the coreclockout domain. On the lane it emits comma fill between blocks, forwards whole blocks without interleaving, and inserts space words while the far end asserts busy. It also enforces a minimum comma gap between blocks, discards stray words that do not start a block, and keeps per-source block and discard counters.

---
 rtl/xmit_link_pkg.sv | 14 +
 rtl/xmit_link_arbiter_if.sv | 27 ++
 rtl/xmit_src_counters.sv | 29 ++
 rtl/xmit_link_arbiter.sv | 107 ++++++++++
 tb/tb_xmit_link_arbiter.sv | 157 +++++++++++++++
 5 files changed

// File: rtl/xmit_link_pkg.sv
// xmit_link_pkg: lane word codes, state encoding and counter widths for xmit_link_arbiter
package xmit_link_pkg;
  localparam int WORD_W = 16;
  localparam int BLK_W = 16;
  localparam int DISC_W = 8;
  localparam int ABORT_W = 8;
  localparam logic [WORD_W-1:0] COMMA = 16'hC5BC;
  localparam logic [WORD_W-1:0] SPACE = 16'hF7F7;
  localparam logic [1:0] CTL_COMMA = 2'b01;
  localparam logic [1:0] CTL_SPACE = 2'b11;
  localparam logic [1:0] CTL_DATA = 2'b00;
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] XFER = 1'b1;
endpackage

// File: rtl/xmit_link_arbiter_if.sv
// xmit_link_arbiter_if: source FIFO heads, lane outputs and counters of the transmit lane arbiter
interface xmit_link_arbiter_if;
  import xmit_link_pkg::*;
  logic [1:0] src_empty;
  logic [1:0] src_fst;
  logic [1:0] src_lst;
  logic [1:0] src_rdreq;
  logic [WORD_W-1:0] src0_q;
  logic [WORD_W-1:0] src1_q;
  logic busy;
  logic [WORD_W-1:0] tx_datain;
  logic [1:0] tx_ctrlenable;
  logic [1:0] grant;
  logic [BLK_W-1:0] blk_cnt0;
  logic [BLK_W-1:0] blk_cnt1;
  logic [DISC_W-1:0] disc_cnt0;
  logic [DISC_W-1:0] disc_cnt1;
  logic [ABORT_W-1:0] abort_cnt;
  modport master (
    output src_empty, src_fst, src_lst, src0_q, src1_q, busy,
    input src_rdreq, tx_datain, tx_ctrlenable, grant, blk_cnt0, blk_cnt1, disc_cnt0, disc_cnt1, abort_cnt
  );
  modport slave (
    input src_empty, src_fst, src_lst, src0_q, src1_q, busy,
    output src_rdreq, tx_datain, tx_ctrlenable, grant, blk_cnt0, blk_cnt1, disc_cnt0, disc_cnt1, abort_cnt
  );
endinterface

// File: rtl/xmit_src_counters.sv
// xmit_src_counters: per-source completed-block counter (wrapping) and discard counter (saturating)
module xmit_src_counters
  import xmit_link_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              blk_inc,
  input  logic              disc_inc,
  output logic [BLK_W-1:0]  blk_cnt,
  output logic [DISC_W-1:0] disc_cnt
);
  logic [BLK_W-1:0] blk_q, blk_d;
  logic [DISC_W-1:0] disc_q, disc_d;
  always_comb begin
    blk_d = blk_inc ? blk_q + 1'b1 : blk_q;
    disc_d = (disc_inc && !(&disc_q)) ? disc_q + 1'b1 : disc_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      blk_q <= '0;
      disc_q <= '0;
    end else begin
      blk_q <= blk_d;
      disc_q <= disc_d;
    end
  end
  assign blk_cnt = blk_q;
  assign disc_cnt = disc_q;
endmodule

// File: rtl/xmit_link_arbiter.sv
// xmit_link_arbiter: block-granular two-source arbiter driving one transmit lane with comma fill and busy spacing
module xmit_link_arbiter
  import xmit_link_pkg::*;
#(
  parameter int COMMA_GAP = 4,
  parameter int STALL_MAX = 1023
) (
  input logic coreclockout,
  input logic run,
  xmit_link_arbiter_if.slave bus
);
  localparam int SW = $clog2(STALL_MAX + 1);
  logic [0:0] state_q, state_d;
  logic [1:0] grant_q, grant_d, ctl_q, ctl_d, rdy, rdreq, blk_inc, disc_inc;
  logic ptr_q, ptr_d, g, pop, last, abort, done, rst;
  logic [3:0] gap_q, gap_d;
  logic [SW-1:0] stall_q, stall_d;
  logic [WORD_W-1:0] tx_q, tx_d;
  logic [ABORT_W-1:0] abort_q, abort_d;
  logic [BLK_W-1:0] blk0, blk1;
  logic [DISC_W-1:0] disc0, disc1;
  assign rst = !run;
  assign rdy = ~bus.src_empty & bus.src_fst;
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d = ptr_q;
    gap_d = gap_q;
    stall_d = stall_q;
    abort_d = abort_q;
    tx_d = COMMA;
    ctl_d = CTL_COMMA;
    rdreq = '0;
    blk_inc = '0;
    disc_inc = '0;
    g = grant_q[1];
    pop = 1'b0;
    last = 1'b0;
    abort = 1'b0;
    done = 1'b0;
    if (state_q == IDLE) begin
      disc_inc = ~bus.src_empty & ~bus.src_fst & {2{run}};
      rdreq = disc_inc;
      gap_d = &gap_q ? gap_q : gap_q + 1'b1;
      if (int'(gap_q) + 1 >= COMMA_GAP && |rdy) begin
        state_d = XFER;
        grant_d = (rdy[1] && (!rdy[0] || ptr_q)) ? 2'b10 : 2'b01;
        stall_d = '0;
      end
    end else begin
      pop = !bus.src_empty[g] && !bus.busy && run;
      last = pop && bus.src_lst[g];
      abort = !pop && !bus.busy && stall_q == SW'(STALL_MAX - 1);
      done = last || abort;
      rdreq[g] = pop;
      blk_inc[g] = last;
      tx_d = pop ? (g ? bus.src1_q : bus.src0_q) : SPACE;
      ctl_d = pop ? CTL_DATA : CTL_SPACE;
      stall_d = pop ? '0 : bus.busy ? stall_q : stall_q + 1'b1;
      abort_d = (abort && !(&abort_q)) ? abort_q + 1'b1 : abort_q;
      if (done) begin
        state_d = IDLE;
        grant_d = '0;
        ptr_d = !g;
        gap_d = '0;
      end
    end
  end
  always_ff @(posedge coreclockout) begin
    if (!run) begin
      state_q <= IDLE;
      grant_q <= '0;
      ptr_q <= 1'b0;
      gap_q <= 4'(COMMA_GAP);
      stall_q <= '0;
      abort_q <= '0;
      tx_q <= COMMA;
      ctl_q <= CTL_COMMA;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q <= ptr_d;
      gap_q <= gap_d;
      stall_q <= stall_d;
      abort_q <= abort_d;
      tx_q <= tx_d;
      ctl_q <= ctl_d;
    end
  end
  xmit_src_counters u_cnt0 (
    .clk(coreclockout), .rst(rst), .blk_inc(blk_inc[0]), .disc_inc(disc_inc[0]),
    .blk_cnt(blk0), .disc_cnt(disc0)
  );
  xmit_src_counters u_cnt1 (
    .clk(coreclockout), .rst(rst), .blk_inc(blk_inc[1]), .disc_inc(disc_inc[1]),
    .blk_cnt(blk1), .disc_cnt(disc1)
  );
  assign bus.src_rdreq = rdreq;
  assign bus.tx_datain = tx_q;
  assign bus.tx_ctrlenable = ctl_q;
  assign bus.grant = grant_q;
  assign bus.blk_cnt0 = blk0;
  assign bus.blk_cnt1 = blk1;
  assign bus.disc_cnt0 = disc0;
  assign bus.disc_cnt1 = disc1;
  assign bus.abort_cnt = abort_q;
endmodule

// File: tb/tb_xmit_link_arbiter.sv
// tb_xmit_link_arbiter: directed self-checking bench for xmit_link_arbiter with two modelled showahead FIFOs
module tb_xmit_link_arbiter;
  import xmit_link_pkg::*;
  localparam logic [17:0] LC = {CTL_COMMA, COMMA};
  localparam logic [17:0] LS = {CTL_SPACE, SPACE};
  logic clk = 1'b0;
  logic run = 1'b0;
  logic flush = 1'b1;
  logic [17:0] mem0 [512];
  logic [17:0] mem1 [512];
  logic [8:0] wp0 = '0, wp1 = '0, rp0 = '0, rp1 = '0;
  logic [17:0] exq[$];
  bit bzq[$];
  int n_chk = 0;
  int n_err = 0;
  always #5 clk = ~clk;
  xmit_link_arbiter_if bus();
  xmit_link_arbiter #(.COMMA_GAP(4), .STALL_MAX(8)) dut (.coreclockout(clk), .run(run), .bus(bus));
  assign bus.src_empty = {wp1 == rp1, wp0 == rp0};
  assign bus.src0_q = mem0[rp0][15:0];
  assign bus.src1_q = mem1[rp1][15:0];
  assign bus.src_fst = {mem1[rp1][17], mem0[rp0][17]};
  assign bus.src_lst = {mem1[rp1][16], mem0[rp0][16]};
  always @(posedge clk) begin
    rp0 <= flush ? wp0 : (bus.src_rdreq[0] === 1'b1) ? rp0 + 1'b1 : rp0;
    rp1 <= flush ? wp1 : (bus.src_rdreq[1] === 1'b1) ? rp1 + 1'b1 : rp1;
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic push(input bit s, input bit f, input bit l, input logic [15:0] d);
    if (s) begin
      mem1[wp1] = {f, l, d};
      wp1 = wp1 + 1'b1;
    end else begin
      mem0[wp0] = {f, l, d};
      wp0 = wp0 + 1'b1;
    end
  endtask
  function automatic logic [17:0] ld(input logic [15:0] d);
    return {CTL_DATA, d};
  endfunction
  task automatic ex(input logic [17:0] w, input int n, input bit b);
    repeat (n) begin
      exq.push_back(w);
      bzq.push_back(b);
    end
  endtask
  task automatic play(input string tag);
    for (int i = 0; i < exq.size(); i++) begin
      bus.busy = bzq[i];
      @(negedge clk);
      check($sformatf("%s_%0d", tag, i), {14'd0, bus.tx_ctrlenable, bus.tx_datain}, {14'd0, exq[i]});
    end
    exq.delete();
    bzq.delete();
    bus.busy = 1'b0;
  endtask
  task automatic reset_dut;
    run = 1'b0;
    flush = 1'b1;
    repeat (2) @(negedge clk);
    flush = 1'b0;
    run = 1'b1;
  endtask
  initial begin
    bus.busy = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_lane", {bus.tx_ctrlenable, bus.tx_datain}, LC);
    check("rst_grant", bus.grant, 2'b00);
    check("rst_rdreq", bus.src_rdreq, 2'b00);
    check("rst_blk0", bus.blk_cnt0, 0);
    check("rst_blk1", bus.blk_cnt1, 0);
    check("rst_disc0", bus.disc_cnt0, 0);
    check("rst_disc1", bus.disc_cnt1, 0);
    check("rst_abort", bus.abort_cnt, 0);
    flush = 1'b0;
    run = 1'b1;
    ex(LC, 4, 0);
    play("idle");
    for (int i = 1; i <= 5; i++) push(0, i == 1, i == 5, 16'(i));
    ex(LC, 1, 0);
    for (int i = 1; i <= 5; i++) ex(ld(16'(i)), 1, 0);
    ex(LC, 4, 0);
    play("single");
    check("single_blk0", bus.blk_cnt0, 1);
    check("single_grant", bus.grant, 2'b00);
    reset_dut;
    push(0, 1, 0, 16'h0A01); push(0, 0, 0, 16'h0A02); push(0, 0, 1, 16'h0A03);
    push(1, 1, 0, 16'h0B01); push(1, 0, 1, 16'h0B02);
    push(0, 1, 0, 16'h0C01); push(0, 0, 1, 16'h0C02);
    ex(LC, 1, 0); ex(ld(16'h0A01), 1, 0); ex(ld(16'h0A02), 1, 0); ex(ld(16'h0A03), 1, 0);
    ex(LC, 4, 0); ex(ld(16'h0B01), 1, 0); ex(ld(16'h0B02), 1, 0);
    ex(LC, 4, 0); ex(ld(16'h0C01), 1, 0); ex(ld(16'h0C02), 1, 0); ex(LC, 1, 0);
    play("contend");
    check("contend_blk0", bus.blk_cnt0, 2);
    check("contend_blk1", bus.blk_cnt1, 1);
    reset_dut;
    for (int i = 1; i <= 6; i++) push(0, i == 1, i == 6, 16'h0D00 + 16'(i));
    ex(LC, 1, 0); ex(ld(16'h0D01), 1, 0); ex(ld(16'h0D02), 1, 0); ex(LS, 3, 1);
    for (int i = 3; i <= 6; i++) ex(ld(16'h0D00 + 16'(i)), 1, 0);
    ex(LC, 1, 0);
    play("busy");
    check("busy_blk0", bus.blk_cnt0, 1);
    check("busy_abort", bus.abort_cnt, 0);
    reset_dut;
    repeat (260) push(0, 0, 0, 16'h0BAD);
    push(1, 0, 0, 16'h1111);
    push(1, 0, 0, 16'h2222);
    #1 check("disc_both_rdreq", bus.src_rdreq, 2'b11);
    repeat (2) @(negedge clk);
    check("disc1_cnt", bus.disc_cnt1, 2);
    check("disc_lane", {bus.tx_ctrlenable, bus.tx_datain}, LC);
    check("disc_grant", bus.grant, 2'b00);
    repeat (260) @(negedge clk);
    check("disc0_sat", bus.disc_cnt0, 8'hFF);
    check("disc_idle_rdreq", bus.src_rdreq, 2'b00);
    push(1, 1, 1, 16'h5A5A);
    ex(LC, 1, 0); ex(ld(16'h5A5A), 1, 0); ex(LC, 4, 0);
    play("oneword");
    check("oneword_blk1", bus.blk_cnt1, 1);
    push(0, 1, 0, 16'h0E01);
    push(0, 0, 0, 16'h0E02);
    ex(LC, 1, 0); ex(ld(16'h0E01), 1, 0); ex(ld(16'h0E02), 1, 0); ex(LS, 20, 1); ex(LS, 7, 0);
    play("stall_a");
    check("stall_a_abort", bus.abort_cnt, 0);
    check("stall_a_grant", bus.grant, 2'b01);
    ex(LS, 1, 0); ex(LC, 4, 0);
    play("stall_b");
    check("stall_abort", bus.abort_cnt, 1);
    check("stall_blk0", bus.blk_cnt0, 0);
    check("stall_grant", bus.grant, 2'b00);
    for (int i = 1; i <= 6; i++) push(0, i == 1, i == 6, 16'h0F00 + 16'(i));
    ex(LC, 1, 0); ex(ld(16'h0F01), 1, 0); ex(ld(16'h0F02), 1, 0);
    play("midrst");
    run = 1'b0;
    flush = 1'b1;
    #1 check("midrst_rdreq", bus.src_rdreq, 2'b00);
    @(negedge clk);
    check("midrst_lane", {bus.tx_ctrlenable, bus.tx_datain}, LC);
    check("midrst_grant", bus.grant, 2'b00);
    check("midrst_blk1", bus.blk_cnt1, 0);
    check("midrst_disc0", bus.disc_cnt0, 0);
    check("midrst_disc1", bus.disc_cnt1, 0);
    check("midrst_abort", bus.abort_cnt, 0);
    flush = 1'b0;
    run = 1'b1;
    ex(LC, 2, 0);
    play("after_rst");
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
